// File: rtl/uart_sim_pkg.sv
// Shared types and constants for the simulation UART transmitter.
// Build option: UART_SIM_TX_PARITY_EN adds an even-parity bit to each frame.
package uart_sim_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  // Clock cycles per bit, rounded to nearest.
  function automatic int calc_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_sim_tx_sync_fifo.sv
// First-word fall-through FIFO; head data is valid whenever empty is low.
// Latency: write visible one cycle after push. Push while full is dropped unless a pop frees a slot.
// Backpressure: full asserted at DEPTH entries.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  generate
    if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_depth_chk
      $error("sync_fifo: DEPTH must be a power of two and at least 2");
    end
  endgenerate

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Level MSB is set only when every entry is occupied.
  assign full     = level[AW];
  assign empty    = (level == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_sim_tx.sv
// UART 8N1 transmitter (8E1 when UART_SIM_TX_PARITY_EN is defined) fed by a byte FIFO.
// Latency: start bit appears 2 cycles after a push into an empty, idle transmitter.
// Backpressure: o_ready low while the FIFO is full; pushes then are dropped.
module uart_sim_tx
  import uart_sim_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 12_500_000,
  parameter int BAUD_RATE   = 115_200,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    i_data,
  input  logic                          i_valid,
  output logic                          o_ready,
  output logic                          o_uart_tx,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

  localparam int          DIV      = calc_div(CLK_FREQ_HZ, BAUD_RATE);
  localparam logic [15:0] DIV_LAST = 16'(DIV - 1);
  localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);

  generate
    if (DIV < 2 || DIV > 65535) begin : g_div_chk
      $error("uart_sim_tx: bit period out of range for the 16-bit baud counter");
    end
    if (STOP_BITS != 1) begin : g_stop_chk
      $error("uart_sim_tx: only one stop bit is supported");
    end
  endgenerate

  state_t      state;
  state_t      state_nxt;
  logic [15:0] baud_cnt;
  logic        baud_done;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
  logic        tx_nxt;
  logic        fifo_pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic [7:0]  fifo_head;
  logic        fifo_push;
`ifdef UART_SIM_TX_PARITY_EN
  logic        parity;
`endif

  assign o_ready   = !fifo_full;
  assign fifo_push = i_valid && o_ready;
  assign baud_done = (baud_cnt == DIV_LAST);
  assign o_busy    = (state != IDLE) || (o_fifo_level != '0);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (i_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (o_fifo_level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (!fifo_empty) state_nxt = START;
      START:  if (baud_done) state_nxt = DATA;
      DATA: begin
        if (baud_done && bit_idx == LAST_BIT) begin
`ifdef UART_SIM_TX_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = STOP;
`endif
        end
      end
`ifdef UART_SIM_TX_PARITY_EN
      PARITY: if (baud_done) state_nxt = STOP;
`endif
      STOP:   if (baud_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Line value is computed from the current state and registered, so the pin
  // trails the state by one cycle and never glitches.
  always_comb begin
    tx_nxt   = 1'b1;
    fifo_pop = 1'b0;
    case (state)
      IDLE:   fifo_pop = !fifo_empty;
      START:  tx_nxt   = 1'b0;
      DATA:   tx_nxt   = shift[0];
`ifdef UART_SIM_TX_PARITY_EN
      PARITY: tx_nxt   = parity;
`endif
      default: tx_nxt  = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) o_uart_tx <= 1'b1;
    else     o_uart_tx <= tx_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
`ifdef UART_SIM_TX_PARITY_EN
      parity   <= 1'b0;
`endif
    end else if (state == IDLE) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
      if (!fifo_empty) begin
        shift  <= fifo_head;
`ifdef UART_SIM_TX_PARITY_EN
        parity <= ^fifo_head;
`endif
      end
    end else if (baud_done) begin
      baud_cnt <= '0;
      if (state == DATA) begin
        shift   <= shift >> 1;
        bit_idx <= bit_idx + 3'd1;
      end
    end else begin
      baud_cnt <= baud_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_uart_sim_tx.sv
// Directed bench for uart_sim_tx: a line decoder checks every frame cycle-by-cycle against a byte scoreboard.
module tb_uart_sim_tx;

  localparam int DIV = 109;
`ifdef UART_SIM_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] i_data = 8'h00;
  logic       i_valid = 1'b0;
  logic       o_ready;
  logic       o_uart_tx;
  logic       o_busy;
  logic [4:0] o_fifo_level;

  uart_sim_tx dut (
    .clk          (clk),
    .rst          (rst),
    .i_data       (i_data),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .o_uart_tx    (o_uart_tx),
    .o_busy       (o_busy),
    .o_fifo_level (o_fifo_level)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [7:0] exp_q[$];
  int         starts[$];
  int         frames_done = 0;
  bit         dec_active = 1'b0;
  bit         dec_unexp = 1'b0;
  int         dec_pos = 0;
  int         dec_bad = 0;
  logic [10:0] dec_bits = '1;

  // Bit 0 is the start bit; unused upper bits stay high.
  function automatic logic [10:0] frame_bits(input logic [7:0] d);
`ifdef UART_SIM_TX_PARITY_EN
    return {1'b1, ^d, d, 1'b0};
`else
    return {2'b11, d, 1'b0};
`endif
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      dec_active = 1'b0;
    end else begin
      if (!dec_active && o_uart_tx === 1'b0) begin
        dec_active = 1'b1;
        dec_pos    = 0;
        dec_bad    = 0;
        starts.push_back(cyc);
        if (exp_q.size() == 0) begin
          dec_unexp = 1'b1;
          dec_bits  = '1;
        end else begin
          dec_unexp = 1'b0;
          dec_bits  = frame_bits(exp_q.pop_front());
        end
      end
      if (dec_active) begin
        if (o_uart_tx !== dec_bits[dec_pos / DIV]) dec_bad++;
        dec_pos++;
        if (dec_pos == NB * DIV) begin
          dec_active = 1'b0;
          frames_done++;
          chk("unexpected_frame", 32'(dec_unexp), 0);
          chk("frame_bits_bad_cycles", dec_bad, 0);
        end
      end
    end
  end

  // Drives one byte for one clock; the caller drops i_valid afterwards.
  task automatic send(input logic [7:0] b);
    i_data  = b;
    i_valid = 1'b1;
    @(posedge clk);
    exp_q.push_back(b);
    #1;
  endtask

  task automatic wait_start(input int n, input int budget, output int s);
    int k = 0;
    while (starts.size() == n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("start_timeout", 32'(k < budget), 1);
    s = (starts.size() > n) ? starts[n] : 0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || dec_active || o_busy !== 1'b0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_timeout"}, 32'(k < budget), 1);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int s, acc, n, lvl, bad, fd, ns;

    repeat (3) @(negedge clk);
    chk("rst_tx", o_uart_tx, 1);
    chk("rst_ready", o_ready, 1);
    chk("rst_busy", o_busy, 0);
    chk("rst_level", o_fifo_level, 0);
    rst = 1'b0;

    bad = 0;
    repeat (2000) begin
      @(negedge clk);
      if (o_uart_tx !== 1'b1 || o_busy !== 1'b0 || o_fifo_level !== 5'd0 || o_ready !== 1'b1) bad++;
    end
    chk("idle_2000_bad_cycles", bad, 0);
    chk("idle_no_frames", starts.size(), 0);

    // Single frame: latency, bit timing, busy fall.
    n = starts.size();
    send(8'h55);
    acc = cyc;
    i_valid = 1'b0;
    wait_start(n, 10, s);
    chk("start_latency", s - acc, 2);
    while (cyc < s + NB * DIV - 2) @(negedge clk);
    chk("busy_in_frame", o_busy, 1);
    @(negedge clk);
    @(negedge clk);
    chk("busy_after_frame", o_busy, 0);
    wait_idle("f55", 2 * NB * DIV);
    chk("frames_after_55", frames_done, 1);

    // Back-to-back frames: exactly one idle cycle between them.
    n = starts.size();
    send(8'hA5);
    send(8'h00);
    send(8'hFF);
    i_valid = 1'b0;
    wait_idle("b2b", 4 * NB * DIV);
    chk("frames_after_b2b", frames_done, 4);
    chk("b2b_gap1", starts[n+1] - starts[n], NB * DIV + 1);
    chk("b2b_gap2", starts[n+2] - starts[n+1], NB * DIV + 1);

    // Fill the FIFO behind an active frame; overflow pushes are dropped.
    n = starts.size();
    send(8'h40);
    i_valid = 1'b0;
    wait_start(n, 10, s);
    lvl = 0;
    for (int i = 0; i < 20; i++) begin
      i_data  = 8'(8'h80 + i);
      i_valid = 1'b1;
      chk("ready_fill", o_ready, 32'(lvl < 16));
      @(posedge clk);
      if (lvl < 16) begin
        exp_q.push_back(8'(8'h80 + i));
        lvl++;
      end
      #1;
      chk("level_fill", o_fifo_level, lvl);
    end
    i_valid = 1'b0;
    chk("level_full", o_fifo_level, 16);
    chk("ready_full", o_ready, 0);
    wait_idle("fill", 18 * NB * DIV + 100);
    chk("frames_after_fill", frames_done, 21);

    // Reset mid-frame discards everything.
    n = starts.size();
    send(8'h3C);
    for (int k = 0; k < 5; k++) send(8'(8'h61 + k));
    i_valid = 1'b0;
    wait_start(n, 10, s);
    while (cyc < s + 500) @(negedge clk);
    chk("level_before_rst", o_fifo_level, 5);
    #1;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("async_rst_tx", o_uart_tx, 1);
    chk("async_rst_level", o_fifo_level, 0);
    chk("async_rst_busy", o_busy, 0);
    chk("async_rst_ready", o_ready, 1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    fd = frames_done;
    ns = starts.size();
    bad = 0;
    repeat (1500) begin
      @(negedge clk);
      if (o_uart_tx !== 1'b1 || o_busy !== 1'b0 || o_fifo_level !== 5'd0) bad++;
    end
    chk("post_rst_quiet_bad_cycles", bad, 0);
    chk("post_rst_no_starts", starts.size(), ns);
    chk("post_rst_no_frames", frames_done, fd);
    send(8'h96);
    i_valid = 1'b0;
    wait_idle("after_rst", 2 * NB * DIV);
    chk("frames_after_rst", frames_done, fd + 1);

`ifdef UART_SIM_TX_PARITY_EN
    // Odd-weight byte carries parity 1, even-weight byte parity 0.
    n = starts.size();
    fd = frames_done;
    send(8'h07);
    send(8'h03);
    i_valid = 1'b0;
    wait_idle("parity", 3 * NB * DIV);
    chk("frames_after_parity", frames_done, fd + 2);
    chk("parity_gap", starts[n+1] - starts[n], 11 * DIV + 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
